// File: rtl/tivi_pkg.sv
// Shared types and defaults for the video subsystem: read-tag encoding,
// arbiter grant encoding and VRAM geometry.
package tivi_pkg;

  localparam int VRAM_ADDR_W     = 14;
  localparam int RAM_LAT_DEFAULT = 1;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_WR   = 2'd2,
    GNT_PF   = 2'd3
  } grant_e;

endpackage

// File: rtl/vram_tag_pipe.sv
// Shift register of {tag, addr} that follows each issued RAM read until its
// data appears on ram_rdata; the last stage lines up with the returning data.
module vram_tag_pipe
  import tivi_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = VRAM_ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    tag_i,
  input  logic [AW-1:0] addr_i,
  output logic [1:0]    tag_o,
  output logic [AW-1:0] addr_o,
  output logic          cpu_busy_o
);

  tag_e          tag_q  [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= TAG_NONE;
        addr_q[i] <= '0;
      end
    end else begin
      tag_q[0]  <= tag_e'(tag_i);
      addr_q[0] <= addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        tag_q[i]  <= tag_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  // A CPU read anywhere in flight blocks a duplicate prefetch.
  always_comb begin
    cpu_busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tag_q[i] == TAG_CPU) cpu_busy_o = 1'b1;
    end
  end

  assign tag_o  = tag_q[DEPTH-1];
  assign addr_o = addr_q[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches, CPU writes and CPU read-prefetch of
// the current VRAM address share one registered RAM port.
module vram_arbiter
  import tivi_pkg::*;
#(
  parameter int ADDR_W        = VRAM_ADDR_W,
  parameter int RAM_LAT       = RAM_LAT_DEFAULT,
  parameter int MAX_VID_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_wren,
  output logic [7:0]        vdata_in,
  output logic              vdata_valid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_rdata,
  output logic              vid_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              wr_overrun
);

  localparam int                CNT_W   = $clog2(MAX_VID_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_VID_BURST);

  logic              wren_q;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_overrun_q, wr_overrun_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic              pf_need_q, pf_need_d;
  logic [7:0]        vdata_q, vdata_d;
  logic              vdata_valid_q, vdata_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;

  grant_e            gnt;
  logic [1:0]        tag_in, ret_tag;
  logic [ADDR_W-1:0] tag_addr_in, ret_addr;
  logic              cpu_busy, capture, pf_can, force_cpu;

  assign capture   = cpu_wren & ~wren_q;
  assign pf_can    = pf_need_q & ~cpu_busy;
  assign force_cpu = (cnt_q == CNT_MAX) & (wr_pend_q | pf_can);

  // vid_req is held by scanout until vid_ack; a request is transferred in the
  // cycle where both are high, and its data returns on vid_rvalid later.
  always_comb begin
    gnt = GNT_IDLE;
    if (vid_req && !force_cpu) gnt = GNT_VID;
    else if (wr_pend_q)        gnt = GNT_WR;
    else if (pf_can)           gnt = GNT_PF;
  end

  always_comb begin
    wr_pend_d     = wr_pend_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_overrun_d  = wr_overrun_q;
    pf_addr_d     = pf_addr_q;
    pf_need_d     = pf_need_q;
    vdata_d       = vdata_q;
    vdata_valid_d = vdata_valid_q;
    cnt_d         = '0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_we_d      = 1'b0;
    tag_in        = TAG_NONE;
    tag_addr_in   = '0;

    if (gnt == GNT_WR) wr_pend_d = 1'b0;
    if (capture) begin
      wr_addr_d = cpu_addr;
      wr_data_d = cpu_wdata;
      wr_pend_d = 1'b1;
      if (wr_pend_q && gnt != GNT_WR) wr_overrun_d = 1'b1;
    end

    case (gnt)
      GNT_VID: begin
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        ram_addr_d  = vid_addr;
        tag_in      = TAG_VID;
        tag_addr_in = vid_addr;
      end
      GNT_WR: begin
        ram_addr_d  = wr_addr_q;
        ram_wdata_d = wr_data_q;
        ram_we_d    = 1'b1;
      end
      GNT_PF: begin
        ram_addr_d  = cpu_addr;
        tag_in      = TAG_CPU;
        tag_addr_in = cpu_addr;
        pf_addr_d   = cpu_addr;
      end
      default: ;
    endcase

    if (cpu_addr != pf_addr_q) begin
      pf_need_d     = 1'b1;
      vdata_valid_d = 1'b0;
    end

    // A return is only trusted while still wanted for the address now shown.
    if (ret_tag == TAG_CPU && ret_addr == cpu_addr && pf_need_q) begin
      vdata_d       = ram_rdata;
      vdata_valid_d = 1'b1;
      pf_need_d     = 1'b0;
      pf_addr_d     = cpu_addr;
    end

    // Write-through wins over any same-cycle read return, which would be stale.
    if (gnt == GNT_WR) begin
      if (wr_addr_q == cpu_addr) begin
        vdata_d       = wr_data_q;
        vdata_valid_d = 1'b1;
        pf_need_d     = 1'b0;
        pf_addr_d     = cpu_addr;
      end else if (wr_addr_q == pf_addr_q) begin
        pf_need_d     = 1'b1;
        vdata_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wren_q        <= 1'b0;
      wr_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_overrun_q  <= 1'b0;
      pf_addr_q     <= '0;
      pf_need_q     <= 1'b0;
      vdata_q       <= '0;
      vdata_valid_q <= 1'b0;
      cnt_q         <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
    end else begin
      wren_q        <= cpu_wren;
      wr_pend_q     <= wr_pend_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_overrun_q  <= wr_overrun_d;
      pf_addr_q     <= pf_addr_d;
      pf_need_q     <= pf_need_d;
      vdata_q       <= vdata_d;
      vdata_valid_q <= vdata_valid_d;
      cnt_q         <= cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_we_q      <= ram_we_d;
    end
  end

  vram_tag_pipe #(
    .DEPTH (RAM_LAT + 1),
    .AW    (ADDR_W)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .tag_i      (tag_in),
    .addr_i     (tag_addr_in),
    .tag_o      (ret_tag),
    .addr_o     (ret_addr),
    .cpu_busy_o (cpu_busy)
  );

  assign vid_ack     = (gnt == GNT_VID) & ~reset;
  assign vid_rvalid  = (ret_tag == TAG_VID) & ~reset;
  assign vid_rdata   = vid_rvalid ? ram_rdata : 8'h00;
  assign vdata_in    = vdata_q;
  assign vdata_valid = vdata_valid_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign wr_overrun  = wr_overrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: synchronous RAM model, video requester, directed CPU
// scenarios and scoreboard queues drained by output monitors.
module tb_vram_arbiter;
  import tivi_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_wren;
  logic [7:0]    vdata_in;
  logic          vdata_valid;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [7:0]    vid_rdata;
  logic          vid_rvalid;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          wr_overrun;

  int n_vec = 0;
  int n_err = 0;
  int rv_count = 0;

  logic [7:0]      cpu_exp_q[$];
  logic [7:0]      vid_exp_q[$];
  logic [AW+7:0]   we_exp_q[$];
  logic [7:0]      mem [0:(1<<AW)-1];
  logic            vid_on = 1'b0;
  logic            prev_valid = 1'b0;

  // ---------------- clock / DUT / RAM ----------------
  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wren    (cpu_wren),
    .vdata_in    (vdata_in),
    .vdata_valid (vdata_valid),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_ack     (vid_ack),
    .vid_rdata   (vid_rdata),
    .vid_rvalid  (vid_rvalid),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata),
    .wr_overrun  (wr_overrun)
  );

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_first_ack();
    int n;
    n = 0;
    @(negedge clk);
    while (!vid_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("vid_ack_seen", {31'd0, vid_ack}, 32'd1);
  endtask

  // ---------------- video requester ----------------
  initial begin
    logic acked;
    vid_req  = 1'b0;
    vid_addr = 14'h1000;
    forever begin
      @(negedge clk);
      acked = !reset && vid_req && vid_ack;
      if (acked) vid_exp_q.push_back(mem[vid_addr]);
      @(posedge clk);
      #1;
      if (acked) vid_addr = vid_addr + 1'b1;
      vid_req = vid_on;
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (vid_rvalid) rv_count++;
    if (!reset && vid_rvalid) begin
      if (vid_exp_q.size() == 0) unexpected("vid_rdata", {24'd0, vid_rdata});
      else check("vid_rdata", {24'd0, vid_rdata}, {24'd0, vid_exp_q.pop_front()});
    end
    if (!reset && ram_we) begin
      if (we_exp_q.size() == 0) unexpected("ram_write", {10'd0, ram_addr, ram_wdata});
      else check("ram_write", {10'd0, ram_addr, ram_wdata}, {10'd0, we_exp_q.pop_front()});
    end
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (vdata_valid && !prev_valid) begin
        if (cpu_exp_q.size() == 0) unexpected("vdata_in", {24'd0, vdata_in});
        else check("vdata_in", {24'd0, vdata_in}, {24'd0, cpu_exp_q.pop_front()});
      end
      prev_valid = vdata_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int m;
    int rv0;
    logic [19:0] trace;

    reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_wren = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[14'h0123] = 8'h5A;
    mem[14'h0010] = 8'h31;
    mem[14'h0011] = 8'h42;
    for (int i = 'h1000; i < 'h1100; i++) mem[i] = 8'(i) ^ 8'h3C;

    tick(3);
    @(negedge clk);
    check("reset_ram_addr", {18'd0, ram_addr}, 32'd0);
    check("reset_outs", {8'd0, vdata_in, ram_wdata, vid_rdata, vdata_valid, vid_ack,
                         vid_rvalid, ram_we, wr_overrun, 3'd0}, 32'd0);

    // Prefetch after reset.
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_addr = 14'h0123;
    cpu_exp_q.push_back(8'h5A);
    n = 0;
    @(negedge clk);
    while (ram_addr != 14'h0123 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pf_issue_addr", {18'd0, ram_addr}, 32'h0123);
    check("pf_issue_we", {31'd0, ram_we}, 32'd0);
    m = 0;
    while (!vdata_valid && m < 20) begin
      @(negedge clk);
      m++;
    end
    check("pf_latency", m, 32'd2);

    // Held write strobe captures once, with write-through.
    tick(2);
    cpu_addr = 14'h0200; cpu_wdata = 8'hA5; cpu_wren = 1'b1;
    we_exp_q.push_back({14'h0200, 8'hA5});
    cpu_exp_q.push_back(8'hA5);
    tick(6);
    cpu_wren = 1'b0;
    tick(3);
    @(negedge clk);
    check("wt_vdata", {24'd0, vdata_in}, 32'hA5);
    check("wt_valid", {31'd0, vdata_valid}, 32'd1);
    check("wt_overrun", {31'd0, wr_overrun}, 32'd0);
    check("wt_mem", {24'd0, mem[14'h0200]}, 32'hA5);

    // Video burst with a write pending: 8 acks, one forced CPU cycle, resume.
    tick(1);
    vid_on = 1'b1;
    wait_first_ack();
    trace[19] = vid_ack;
    @(posedge clk); #1;
    cpu_addr = 14'h0300; cpu_wdata = 8'h77; cpu_wren = 1'b1;
    we_exp_q.push_back({14'h0300, 8'h77});
    cpu_exp_q.push_back(8'h77);
    for (int i = 18; i >= 0; i--) begin
      @(negedge clk);
      trace[i] = vid_ack;
    end
    check("ack_pattern", {12'd0, trace}, 32'hFF7FF);
    tick(1);
    vid_on = 1'b0; cpu_wren = 1'b0;
    tick(6);
    @(negedge clk);
    check("burst_vdata", {24'd0, vdata_in}, 32'h77);
    check("burst_overrun", {31'd0, wr_overrun}, 32'd0);

    // Address changes while its prefetch is in flight: stale result dropped.
    tick(1);
    cpu_addr = 14'h0010;
    tick(2);
    cpu_addr = 14'h0011;
    cpu_exp_q.push_back(8'h42);
    m = 0;
    @(negedge clk);
    while (!vdata_valid && m < 20) begin
      @(negedge clk);
      m++;
    end
    check("discard_latency", m, 32'd5);
    check("discard_vdata", {24'd0, vdata_in}, 32'h42);

    // Two write edges under continuous video: overrun, only the second lands.
    tick(2);
    vid_on = 1'b1;
    wait_first_ack();
    @(posedge clk); #1;
    cpu_addr = 14'h0400; cpu_wdata = 8'h11; cpu_wren = 1'b1;
    tick(1);
    cpu_wren = 1'b0;
    tick(1);
    cpu_addr = 14'h0401; cpu_wdata = 8'h22; cpu_wren = 1'b1;
    we_exp_q.push_back({14'h0401, 8'h22});
    cpu_exp_q.push_back(8'h22);
    tick(1);
    cpu_wren = 1'b0;
    tick(10);
    vid_on = 1'b0;
    tick(6);
    @(negedge clk);
    check("ovr_flag", {31'd0, wr_overrun}, 32'd1);
    check("ovr_mem_first", {24'd0, mem[14'h0400]}, 32'h00);
    check("ovr_mem_second", {24'd0, mem[14'h0401]}, 32'h22);
    check("ovr_vdata", {24'd0, vdata_in}, 32'h22);

    // Reset one cycle after an ack: the in-flight read never returns.
    tick(2);
    vid_on = 1'b1;
    wait_first_ack();
    rv0 = rv_count;
    @(posedge clk); #1;
    reset = 1'b1; vid_on = 1'b0; cpu_addr = '0;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_ram_addr", {18'd0, ram_addr}, 32'd0);
    check("rst2_outs", {8'd0, vdata_in, ram_wdata, vid_rdata, vdata_valid, vid_ack,
                        vid_rvalid, ram_we, wr_overrun, 3'd0}, 32'd0);
    tick(5);
    check("rst2_no_rvalid", rv_count - rv0, 32'd0);
    vid_exp_q.delete();

    tick(4);
    check("cpu_q_drained", cpu_exp_q.size(), 32'd0);
    check("vid_q_drained", vid_exp_q.size(), 32'd0);
    check("we_q_drained", we_exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
